// File: rtl/rr_priority_encoder_pkg.sv
// Shared definitions for the registered round-robin priority encoder.
//   DEFAULT_NUM_WIRE : default request vector width
//   sel_mode_e       : selection mode carried by rr_en
//   idx_width()      : index width for a given number of wires
package rr_priority_encoder_pkg;

  localparam int unsigned DEFAULT_NUM_WIRE = 16;

  typedef enum logic {
    SEL_FIXED = 1'b0,
    SEL_RR    = 1'b1
  } sel_mode_e;

  // Index width; never below 1 bit so degenerate widths still elaborate.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : rr_priority_encoder_pkg

// File: rtl/rr_priority_encoder_search_core.sv
// Combinational search over a request vector.
// The vector is rotated right so the search start lands on bit 0. A fixed
// lowest-bit-first pick runs on the rotated vector, and the start offset is
// then added back modulo NUM_WIRE. This handles non-power-of-two widths.
// Ports:
//   req    : request vector
//   ptr    : round-robin start position (always < NUM_WIRE)
//   rr_en  : 0 = fixed priority from bit 0, 1 = search from ptr upward
//   index  : index of the winning wire (0 when none)
//   onehot : one-hot of the winning wire (all zero when none)
//   found  : at least one request bit set
module rr_priority_encoder_search_core
  import rr_priority_encoder_pkg::*;
#(
  parameter  int unsigned NUM_WIRE = DEFAULT_NUM_WIRE,
  localparam int unsigned IDX_W    = idx_width(NUM_WIRE)
) (
  input  logic [NUM_WIRE-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  input  logic                rr_en,
  output logic [IDX_W-1:0]    index,
  output logic [NUM_WIRE-1:0] onehot,
  output logic                found
);

  localparam int unsigned SUM_W = IDX_W + 1;
  localparam int unsigned DBL_W = 2 * NUM_WIRE;

  sel_mode_e             mode;
  logic [IDX_W-1:0]      start;
  logic [DBL_W-1:0]      dbl;
  logic [NUM_WIRE-1:0]   rot;
  logic [IDX_W-1:0]      pick;
  logic                  hit;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_wrapped;

  // Fixed mode searches from bit 0, so the offset is forced to zero.
  assign mode  = sel_mode_e'(rr_en);
  assign start = (mode == SEL_RR) ? ptr : '0;

  // Doubling the vector turns the rotate into a plain shift.
  // Because start < NUM_WIRE, bit i of rot is req[(i + start) mod NUM_WIRE].
  assign dbl = {req, req};
  assign rot = NUM_WIRE'(dbl >> start);

  // Lowest set bit of the rotated vector.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    for (int i = int'(NUM_WIRE) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick = IDX_W'(i);
        hit  = 1'b1;
      end
    end
  end

  // Undo the rotation. Both operands are < NUM_WIRE, so at most one
  // subtraction is needed.
  always_comb begin
    sum         = {1'b0, pick} + {1'b0, start};
    sum_wrapped = sum;
    if (sum >= SUM_W'(NUM_WIRE)) begin
      sum_wrapped = sum - SUM_W'(NUM_WIRE);
    end
  end

  // Outputs are forced to zero when nothing is requested.
  always_comb begin
    found  = hit;
    index  = '0;
    onehot = '0;
    if (hit) begin
      index  = IDX_W'(sum_wrapped);
      onehot = NUM_WIRE'(1) << index;
    end
  end

endmodule : rr_priority_encoder_search_core

// File: rtl/rr_priority_encoder.sv
// Registered, handshaked priority encoder with run-time fixed / round-robin
// selection. A request vector is accepted under valid/ready. The selected
// index, its one-hot and a found flag appear one cycle later in a single
// output register that supports full-throughput capture-while-drain.
// Ports:
//   clk_i       : clock, rising edge
//   arst_ni     : asynchronous active-low reset
//   rr_en_i     : 0 = fixed priority (bit 0 highest), 1 = round-robin
//   wire_in     : request vector
//   in_valid_i  : wire_in valid
//   in_ready_o  : capture possible this cycle (combinational)
//   index_o     : index of selected wire
//   onehot_o    : one-hot of selected wire, zero if none
//   found_o     : captured vector had at least one bit set
//   out_valid_o : output register holds a result
//   out_ready_i : consumer accepts the result
module rr_priority_encoder
  import rr_priority_encoder_pkg::*;
#(
  parameter  int unsigned NUM_WIRE = DEFAULT_NUM_WIRE,
  localparam int unsigned IDX_W    = idx_width(NUM_WIRE)
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic                rr_en_i,
  input  logic [NUM_WIRE-1:0] wire_in,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  output logic [IDX_W-1:0]    index_o,
  output logic [NUM_WIRE-1:0] onehot_o,
  output logic                found_o,
  output logic                out_valid_o,
  input  logic                out_ready_i
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WIRE - 1);

  logic                out_valid_q;
  logic                out_valid_d;
  logic [IDX_W-1:0]    index_q;
  logic [NUM_WIRE-1:0] onehot_q;
  logic                found_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [IDX_W-1:0]    ptr_d;

  logic [IDX_W-1:0]    search_index;
  logic [NUM_WIRE-1:0] search_onehot;
  logic                search_found;
  logic                capture_c;

  // Search on the live input vector, starting from the stored pointer.
  rr_priority_encoder_search_core #(
    .NUM_WIRE (NUM_WIRE)
  ) u_search (
    .req    (wire_in),
    .ptr    (ptr_q),
    .rr_en  (rr_en_i),
    .index  (search_index),
    .onehot (search_onehot),
    .found  (search_found)
  );

  // Ready whenever the output slot is empty or is being drained this cycle.
  assign in_ready_o = !out_valid_q || out_ready_i;
  assign capture_c  = in_valid_i && in_ready_o;

  // Output valid: set on capture, cleared on drain without a new capture.
  always_comb begin
    out_valid_d = out_valid_q;
    if (capture_c) begin
      out_valid_d = 1'b1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Pointer moves past the winner only on a round-robin capture that found one.
  always_comb begin
    ptr_d = ptr_q;
    if (capture_c && rr_en_i && search_found) begin
      ptr_d = (search_index == LAST_IDX) ? '0 : search_index + IDX_W'(1);
    end
  end

  // Control and pointer state.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  // Result payload loads on capture only and otherwise holds.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      index_q  <= '0;
      onehot_q <= '0;
      found_q  <= 1'b0;
    end else if (capture_c) begin
      index_q  <= search_index;
      onehot_q <= search_onehot;
      found_q  <= search_found;
    end
  end

  assign out_valid_o = out_valid_q;
  assign index_o     = index_q;
  assign onehot_o    = onehot_q;
  assign found_o     = found_q;

endmodule : rr_priority_encoder

// File: tb/tb_rr_priority_encoder.sv
// Self-checking bench for rr_priority_encoder: an 8-wire and a 5-wire
// instance share one clock. A behavioural model tracks the output register
// and the round-robin start position of each instance.
module tb_rr_priority_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-wire instance
  logic       arst8_n, rr8, v8, ordy8, irdy8, ov8, f8;
  logic [7:0] w8, oh8;
  logic [2:0] idx8;
  // 5-wire instance
  logic       arst5_n, rr5, v5, ordy5, irdy5, ov5, f5;
  logic [4:0] w5, oh5;
  logic [2:0] idx5;

  rr_priority_encoder #(.NUM_WIRE(8)) u_dut8 (
    .clk_i(clk), .arst_ni(arst8_n), .rr_en_i(rr8), .wire_in(w8),
    .in_valid_i(v8), .in_ready_o(irdy8), .index_o(idx8), .onehot_o(oh8),
    .found_o(f8), .out_valid_o(ov8), .out_ready_i(ordy8)
  );

  rr_priority_encoder #(.NUM_WIRE(5)) u_dut5 (
    .clk_i(clk), .arst_ni(arst5_n), .rr_en_i(rr5), .wire_in(w5),
    .in_valid_i(v5), .in_ready_o(irdy5), .index_o(idx5), .onehot_o(oh5),
    .found_o(f5), .out_valid_o(ov5), .out_ready_i(ordy5)
  );

  int total = 0;
  int bad   = 0;

  // Model state per instance: 0 = 8-wire, 1 = 5-wire.
  int nw    [2] = '{8, 5};
  bit mv    [2];
  bit mf    [2];
  int midx  [2];
  int mptr  [2];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scan n positions from the start (ptr in rr mode, 0 otherwise), wrapping.
  // Returns the first set bit.
  task automatic ref_pick(input logic [7:0] w, input int n, input logic rr,
                          input int ptr, output int idx, output bit fnd);
    int start;
    int j;
    idx   = 0;
    fnd   = 1'b0;
    start = rr ? ptr : 0;
    for (int k = 0; k < n; k++) begin
      j = (start + k) % n;
      if (!fnd && w[j]) begin
        idx = j;
        fnd = 1'b1;
      end
    end
  endtask

  // One clock of activity on instance d. The other instance idles
  // (no request, consumer ready). Only instance d's outputs are checked.
  task automatic beat(input int d, input logic rr, input logic [7:0] w,
                      input logic v, input logic ordy);
    logic       lr [2];
    logic [7:0] lw [2];
    logic       lv [2];
    logic       lo [2];
    int         idx;
    bit         fnd;
    bit         rdy;
    int         obs_v, obs_i, obs_o, obs_f, obs_r;
    for (int e = 0; e < 2; e++) begin
      lr[e] = (e == d) ? rr : 1'b0;
      lw[e] = (e == d) ? w : 8'h00;
      lv[e] = (e == d) ? v : 1'b0;
      lo[e] = (e == d) ? ordy : 1'b1;
    end
    lw[1] = lw[1] & 8'h1f;
    rr8 = lr[0]; w8 = lw[0];      v8 = lv[0]; ordy8 = lo[0];
    rr5 = lr[1]; w5 = lw[1][4:0]; v5 = lv[1]; ordy5 = lo[1];
    #1;
    obs_r = (d == 0) ? int'(irdy8) : int'(irdy5);
    chk("in_ready", obs_r, int'(!mv[d] || lo[d]));
    for (int e = 0; e < 2; e++) begin
      rdy = !mv[e] || lo[e];
      if (lv[e] && rdy) begin
        ref_pick(lw[e], nw[e], lr[e], mptr[e], idx, fnd);
        mv[e]   = 1'b1;
        mf[e]   = fnd;
        midx[e] = idx;
        if (lr[e] && fnd) mptr[e] = (idx == nw[e] - 1) ? 0 : idx + 1;
      end else if (mv[e] && lo[e]) begin
        mv[e] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    obs_v = (d == 0) ? int'(ov8)  : int'(ov5);
    obs_i = (d == 0) ? int'(idx8) : int'(idx5);
    obs_o = (d == 0) ? int'(oh8)  : int'(oh5);
    obs_f = (d == 0) ? int'(f8)   : int'(f5);
    chk("out_valid", obs_v, int'(mv[d]));
    if (mv[d]) begin
      chk("index", obs_i, mf[d] ? midx[d] : 0);
      chk("onehot", obs_o, mf[d] ? (1 << midx[d]) : 0);
      chk("found", obs_f, int'(mf[d]));
    end
  endtask

  initial begin
    logic [7:0] rw;
    int         rd;
    for (int e = 0; e < 2; e++) begin
      mv[e] = 1'b0; mf[e] = 1'b0; midx[e] = 0; mptr[e] = 0;
    end
    arst8_n = 1'b0; arst5_n = 1'b0;
    rr8 = 1'b0; w8 = 8'hff; v8 = 1'b1; ordy8 = 1'b1;
    rr5 = 1'b0; w5 = 5'h1f; v5 = 1'b1; ordy5 = 1'b1;

    // Reset is held with a request pending, so nothing may be captured.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(ov8), 0);
    chk("rst_index", int'(idx8), 0);
    chk("rst_onehot", int'(oh8), 0);
    chk("rst_found", int'(f8), 0);
    chk("rst_in_ready", int'(irdy8), 1);
    chk("rst5_out_valid", int'(ov5), 0);
    arst8_n = 1'b1; arst5_n = 1'b1;

    // Fixed priority: the lowest set bit wins, and it wins again on repeat.
    beat(0, 1'b0, 8'b1010_0100, 1'b1, 1'b1);
    beat(0, 1'b0, 8'b1010_0100, 1'b1, 1'b1);

    // Round-robin, back to back: expected indices 0, 2, 7, 0.
    repeat (4) beat(0, 1'b1, 8'b1000_0101, 1'b1, 1'b1);

    // Empty vector: not found, and the start position does not move.
    beat(0, 1'b1, 8'h00, 1'b1, 1'b1);
    // Wrap: 7, then 0.
    beat(0, 1'b1, 8'b1000_0000, 1'b1, 1'b1);
    beat(0, 1'b1, 8'b0000_0001, 1'b1, 1'b1);

    // Backpressure: hold the result for 3 cycles with a new request waiting.
    beat(0, 1'b0, 8'b0001_0000, 1'b1, 1'b1);
    repeat (3) beat(0, 1'b0, 8'b0000_0010, 1'b1, 1'b0);
    beat(0, 1'b0, 8'b0000_0010, 1'b1, 1'b1);
    beat(0, 1'b0, 8'b0000_0000, 1'b0, 1'b1);

    // Non-power-of-two width: expected indices 0, 4, 0.
    repeat (3) beat(1, 1'b1, 8'b0001_0001, 1'b1, 1'b1);
    // A capture moves the start position to 1; the reset must clear it.
    beat(1, 1'b1, 8'b0001_0001, 1'b1, 1'b0);
    arst5_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(ov5), 0);
    mv[1] = 1'b0; mptr[1] = 0;
    @(posedge clk);
    #2;
    arst5_n = 1'b1;
    beat(1, 1'b1, 8'h00, 1'b0, 1'b1);
    beat(1, 1'b1, 8'b0001_0001, 1'b1, 1'b1);

    // Random traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      rd = int'($urandom_range(0, 1));
      rw = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rw = 8'h00;
      beat(rd, 1'($urandom), rw, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rr_priority_encoder

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Registered, handshaked successor to the combinational priority encoder.
- Accepts a request vector under valid/ready and returns, one cycle later, the binary index and one-hot of the selected wire, plus a found flag.
- Run-time mode select: fixed priority (bit 0 highest) or round-robin (search starts after the last winner).
- Sits between request sources (issue/wakeup logic, port arbitration) and a consumer that may apply backpressure.

Parameters:
- NUM_WIRE, 16, number of request wires; must be >= 2; need not be a power of two.
- IDX_W, $clog2(NUM_WIRE), index width; derived, must not be overridden.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- arst_ni  input  1  asynchronous active-low reset.
- rr_en_i  input  1  0 = fixed priority, 1 = round-robin; sampled at capture.
- wire_in  input  NUM_WIRE  request vector.
- in_valid_i  input  1  wire_in is valid.
- in_ready_o  output  1  block can capture wire_in this cycle.
- index_o  output  IDX_W  index of the selected wire.
- onehot_o  output  NUM_WIRE  one-hot of the selected wire; all zero if none.
- found_o  output  1  at least one wire was set in the captured vector.
- out_valid_o  output  1  output register holds a result.
- out_ready_i  input  1  consumer accepts the result.

Behaviour:
- Reset (arst_ni=0, asynchronous): out_valid_o=0, index_o=0, onehot_o=0, found_o=0, rr pointer ptr_q=0. in_ready_o reads 1 while in reset-released idle.
- Handshake:
  - in_ready_o = !out_valid_o || out_ready_i (combinational).
  - Capture when in_valid_i && in_ready_o.
  - Output beat completes when out_valid_o && out_ready_i.
- Output register:
  - Single stage, 1-cycle latency: data captured at edge N appears at index_o/onehot_o/found_o with out_valid_o=1 after edge N.
  - Full throughput: capture and drain in the same cycle are allowed; the register reloads with the new result and out_valid_o stays 1.
  - Drain with no capture: out_valid_o -> 0; data outputs hold their last value (don't-care while invalid).
  - While out_valid_o=1 && out_ready_i=0: all outputs are stable and in_ready_o=0; wire_in is ignored even if in_valid_i=1.
- Selection, fixed mode (rr_en_i=0): lowest-numbered set bit wins.
- Selection, round-robin mode (rr_en_i=1):
  - Search starts at ptr_q and proceeds upward, wrapping from NUM_WIRE-1 to 0.
  - First set bit found wins.
  - Implementation: rotate right by ptr_q, fixed-priority pick, then add ptr_q modulo NUM_WIRE. The modulo must be correct for non-power-of-two NUM_WIRE.
- Pointer update, at capture only:
  - If rr_en_i=1 and found: ptr_q <= (winner == NUM_WIRE-1) ? 0 : winner+1.
  - Otherwise ptr_q is unchanged. A mode switch does not reset the pointer; fixed-mode captures leave it untouched.
- Empty vector (wire_in all zero) is still a valid transaction: result found_o=0, index_o=0, onehot_o=0, out_valid_o=1, pointer unchanged.
- Invariant: found_o=1 implies onehot_o == 1<<index_o and wire_in[index_o] was set at capture.
- Reset mid-operation: any held result is discarded immediately, ptr_q returns to 0, and no beat is emitted after release until a new capture.
- No X propagation: wire_in bits at positions >= NUM_WIRE do not exist; the pointer never exceeds NUM_WIRE-1.

Decomposition:
- No shared-package types are required.
- IDX_W is computed locally from NUM_WIRE.
- One natural combinational sub-module, rr_search_core (params NUM_WIRE; inputs req, ptr, rr_en; outputs index, onehot, found). It contains the rotate / fixed-pick / unrotate logic.
- The top level holds only the handshake, output register and pointer flops. Expected sizes: ~150 lines top level plus ~100 lines sub-module.

Test Plan (NUM_WIRE=8 unless stated):
- Reset: hold arst_ni=0 with in_valid_i=1 -> out_valid_o=0, onehot_o=0, index_o=0; after release in_ready_o=1 and the first capture uses ptr_q=0.
- Fixed mode: wire_in=8'b1010_0100 captured -> next cycle out_valid_o=1, index_o=2, onehot_o=8'b0000_0100, found_o=1; repeat capture -> index_o=2 again.
- Round-robin rotation: rr_en_i=1, wire_in=8'b1000_0101 on 4 back-to-back beats with out_ready_i=1 -> index_o sequence 0, 2, 7, 0; one result per cycle.
- Empty and wrap:
  - wire_in=0 -> found_o=0, index_o=0, onehot_o=0, pointer unchanged.
  - Then rr capture of 8'b1000_0000 followed by 8'b0000_0001 -> indices 7 then 0.
- Backpressure: capture 8'b0001_0000, hold out_ready_i=0 for 3 cycles while driving 8'b0000_0010 with in_valid_i=1 -> in_ready_o=0, index_o stays 4 and stable; after out_ready_i=1, the next beat returns index 1.
- Non-power-of-two and reset mid-stream:
  - NUM_WIRE=5, rr_en_i=1, wire_in=5'b10001 twice -> indices 0, 4; third beat -> 0.
  - Assert arst_ni with out_valid_o=1 -> out_valid_o drops the same cycle; the next rr capture of 5'b10001 yields 0.
